gate_eval_arbiter: RTL and testbench



---
 rtl/gate_eval_arbiter.sv | 140 ++++++++++++++
 tb/tb_gate_eval_arbiter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/gate_eval_arbiter.sv
// rtl/gate_eval_arbiter.sv - round-robin sequencer sharing one gate datapath among NREQ requesters
// Grant in IDLE, one settle cycle on registered operands, then hold the tagged result until accepted.
module gate_eval_arbiter #(
   parameter  int NREQ = 4,
   localparam int ID_W = $clog2(NREQ)
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [NREQ-1:0]   req_valid_i,
   input  logic [5*NREQ-1:0] req_ops_i,
   output logic [NREQ-1:0]   req_ready_o,
   output logic              dp_a_o,
   output logic              dp_b_o,
   output logic              dp_c_o,
   output logic              dp_g_o,
   output logic              dp_p_o,
   input  logic              dp_x_i,
   input  logic              dp_y_i,
   output logic              rsp_valid_o,
   input  logic              rsp_ready_i,
   output logic [ID_W-1:0]   rsp_id_o,
   output logic              rsp_x_o,
   output logic              rsp_y_o,
   output logic              busy_o,
   output logic [15:0]       done_cnt_o
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      RESP   = 2'd2
   } state_e;

   state_e          state_q, state_d;
   logic [ID_W-1:0] last_grant_q, last_grant_d;
   logic [ID_W-1:0] rsp_id_q, rsp_id_d;
   logic [4:0]      dp_q, dp_d;
   logic            rsp_valid_q, rsp_valid_d;
   logic            rsp_x_q, rsp_x_d;
   logic            rsp_y_q, rsp_y_d;
   logic [15:0]     done_cnt_q, done_cnt_d;

   logic            found;
   logic [ID_W-1:0] grant_idx;
   logic [4:0]      sel_ops;
   logic [NREQ-1:0] ready_c;

   // First valid requester after last_grant, wrapping modulo NREQ.
   always_comb begin
      found     = 1'b0;
      grant_idx = '0;
      for (int k = 1; k <= NREQ; k++) begin
         for (int i = 0; i < NREQ; i++) begin
            if (!found && req_valid_i[i] && (((int'(last_grant_q) + k) % NREQ) == i)) begin
               found     = 1'b1;
               grant_idx = ID_W'(i);
            end
         end
      end
   end

   always_comb begin
      sel_ops = '0;
      ready_c = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (ID_W'(i) == grant_idx) begin
            sel_ops    = req_ops_i[5*i +: 5];
            ready_c[i] = found;
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      rsp_id_d     = rsp_id_q;
      dp_d         = dp_q;
      rsp_valid_d  = rsp_valid_q;
      rsp_x_d      = rsp_x_q;
      rsp_y_d      = rsp_y_q;
      done_cnt_d   = done_cnt_q;
      req_ready_o  = '0;
      unique case (state_q)
         IDLE: begin
            if (found) begin
               req_ready_o  = rst_i ? '0 : ready_c;
               dp_d         = sel_ops;
               rsp_id_d     = grant_idx;
               last_grant_d = grant_idx;
               state_d      = SETTLE;
            end
         end
         SETTLE: begin
            rsp_x_d     = dp_x_i;
            rsp_y_d     = dp_y_i;
            rsp_valid_d = 1'b1;
            state_d     = RESP;
         end
         RESP: begin
            if (rsp_ready_i) begin
               rsp_valid_d = 1'b0;
               done_cnt_d  = done_cnt_q + 16'd1;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= IDLE;
         last_grant_q <= ID_W'(NREQ - 1);
         rsp_id_q     <= '0;
         dp_q         <= '0;
         rsp_valid_q  <= 1'b0;
         rsp_x_q      <= 1'b0;
         rsp_y_q      <= 1'b0;
         done_cnt_q   <= '0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         rsp_id_q     <= rsp_id_d;
         dp_q         <= dp_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_x_q      <= rsp_x_d;
         rsp_y_q      <= rsp_y_d;
         done_cnt_q   <= done_cnt_d;
      end
   end

   assign {dp_a_o, dp_b_o, dp_c_o, dp_g_o, dp_p_o} = dp_q;
   assign rsp_valid_o = rsp_valid_q;
   assign rsp_id_o    = rsp_id_q;
   assign rsp_x_o     = rsp_x_q;
   assign rsp_y_o     = rsp_y_q;
   assign busy_o      = (state_q != IDLE);
   assign done_cnt_o  = done_cnt_q;

endmodule

// File: tb/tb_gate_eval_arbiter.sv
// tb/tb_gate_eval_arbiter.sv - self-checking bench for gate_eval_arbiter
module tb_gate_eval_arbiter;

   localparam int NREQ = 4;

   typedef struct {
      int         req;
      logic [4:0] ops;
      logic       ex;
      logic       ey;
   } vec_t;

   typedef struct {
      logic [1:0] id;
      logic       x;
      logic       y;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  req_valid;
   logic [19:0] req_ops;
   logic [3:0]  req_ready;
   logic        dp_a, dp_b, dp_c, dp_g, dp_p;
   logic        dp_x, dp_y;
   logic        rsp_valid, rsp_ready;
   logic [1:0]  rsp_id;
   logic        rsp_x, rsp_y, busy;
   logic [15:0] done_cnt;

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [15:0] exp_cnt;
   exp_t        sb[$];
   vec_t        tbl[8];
   logic [4:0]  r_ops[4];
   logic        r_ex[4];
   logic        r_ey[4];

   always #5 clk = ~clk;

   // External datapath stand-in.
   assign dp_x = ~((dp_a & dp_g) | dp_c);
   assign dp_y = ((dp_g & dp_b) | dp_p) & dp_g;

   gate_eval_arbiter #(.NREQ(NREQ)) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .req_valid_i (req_valid),
      .req_ops_i   (req_ops),
      .req_ready_o (req_ready),
      .dp_a_o      (dp_a),
      .dp_b_o      (dp_b),
      .dp_c_o      (dp_c),
      .dp_g_o      (dp_g),
      .dp_p_o      (dp_p),
      .dp_x_i      (dp_x),
      .dp_y_i      (dp_y),
      .rsp_valid_o (rsp_valid),
      .rsp_ready_i (rsp_ready),
      .rsp_id_o    (rsp_id),
      .rsp_x_o     (rsp_x),
      .rsp_y_o     (rsp_y),
      .busy_o      (busy),
      .done_cnt_o  (done_cnt)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic next_cycle();
      @(negedge clk);
      #1;
   endtask

   task automatic load(input int r, input vec_t v);
      req_ops[5*r +: 5] = v.ops;
      r_ops[r] = v.ops;
      r_ex[r]  = v.ex;
      r_ey[r]  = v.ey;
   endtask

   task automatic expect_rsp(input string nm);
      exp_t e;
      chk({nm, "_rsp_valid"}, 32'(rsp_valid), 32'd1);
      if (sb.size() == 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL %s_scoreboard: got response, expected none queued", nm);
      end else begin
         e = sb.pop_front();
         chk({nm, "_rsp_id"}, 32'(rsp_id), 32'(e.id));
         chk({nm, "_rsp_x"},  32'(rsp_x),  32'(e.x));
         chk({nm, "_rsp_y"},  32'(rsp_y),  32'(e.y));
      end
   endtask

   // Starts in IDLE shortly after a falling edge; ends in IDLE after the handshake.
   task automatic run_txn(input logic [3:0] mask, input int w, input string nm, input bit keep);
      req_valid = mask;
      rsp_ready = 1'b1;
      sb.push_back('{id: 2'(w), x: r_ex[w], y: r_ey[w]});
      #1;
      chk({nm, "_grant"}, 32'(req_ready), 32'(1) << w);
      next_cycle();
      if (!keep) req_valid = '0;
      #1;
      chk({nm, "_settle_ready"}, 32'(req_ready), 32'd0);
      chk({nm, "_dp"}, 32'({dp_a, dp_b, dp_c, dp_g, dp_p}), 32'(r_ops[w]));
      chk({nm, "_settle_valid"}, 32'(rsp_valid), 32'd0);
      next_cycle();
      expect_rsp(nm);
      chk({nm, "_resp_ready"}, 32'(req_ready), 32'd0);
      next_cycle();
      exp_cnt++;
      chk({nm, "_done_cnt"}, 32'(done_cnt), 32'(exp_cnt));
      chk({nm, "_idle_valid"}, 32'(rsp_valid), 32'd0);
      chk({nm, "_idle_busy"}, 32'(busy), 32'd0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst       = 1'b1;
      req_valid = 4'hF;
      rsp_ready = 1'b0;
      #1;
      chk("rst_ready", 32'(req_ready), 32'd0);
      next_cycle();
      next_cycle();
      chk("rst_ready_held", 32'(req_ready), 32'd0);
      rst       = 1'b0;
      req_valid = '0;
      #1;
      chk("rst_busy",     32'(busy), 32'd0);
      chk("rst_valid",    32'(rsp_valid), 32'd0);
      chk("rst_dp",       32'({dp_a, dp_b, dp_c, dp_g, dp_p}), 32'd0);
      chk("rst_rsp",      32'({rsp_id, rsp_x, rsp_y}), 32'd0);
      chk("rst_done_cnt", 32'(done_cnt), 32'd0);
      exp_cnt = '0;
      sb.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      tbl[0] = '{2, 5'b10010, 1'b0, 1'b0};
      tbl[1] = '{0, 5'b01010, 1'b1, 1'b1};
      tbl[2] = '{0, 5'b00001, 1'b1, 1'b0};
      tbl[3] = '{1, 5'b00100, 1'b0, 1'b0};
      tbl[4] = '{3, 5'b11011, 1'b0, 1'b1};
      tbl[5] = '{3, 5'b00011, 1'b1, 1'b1};
      tbl[6] = '{1, 5'b10001, 1'b1, 1'b0};
      tbl[7] = '{2, 5'b11111, 1'b0, 1'b1};

      rst       = 1'b1;
      req_valid = '0;
      req_ops   = '0;
      rsp_ready = 1'b0;
      exp_cnt   = '0;
      for (int r = 0; r < 4; r++) load(r, tbl[r]);
      do_reset();

      // Reset while SETTLE drops the transaction and restores requester 0 priority.
      req_valid = 4'b0010;
      #1;
      chk("rstsettle_grant", 32'(req_ready), 32'b0010);
      next_cycle();
      rst       = 1'b1;
      req_valid = '0;
      #1;
      chk("rstsettle_busy", 32'(busy), 32'd1);
      next_cycle();
      rst = 1'b0;
      #1;
      chk("rstsettle_busy_after", 32'(busy), 32'd0);
      chk("rstsettle_cnt", 32'(done_cnt), 32'd0);
      for (int c = 0; c < 3; c++) begin
         chk("rstsettle_no_rsp", 32'(rsp_valid), 32'd0);
         next_cycle();
      end
      run_txn(4'hF, 0, "post_rst", 1'b0);

      for (int i = 0; i < 8; i++) begin
         load(tbl[i].req, tbl[i]);
         run_txn(4'(1 << tbl[i].req), tbl[i].req, $sformatf("vec%0d", i), 1'b0);
      end

      // All requesters valid continuously: grants rotate every 3 cycles.
      do_reset();
      for (int r = 0; r < 4; r++) load(r, tbl[r]);
      for (int g = 0; g < 8; g++) run_txn(4'hF, g % 4, $sformatf("rr%0d", g), 1'b1);
      req_valid = '0;

      // Back-pressure on requester 1 while others wait.
      load(1, tbl[4]);
      req_valid = 4'b0010;
      rsp_ready = 1'b0;
      sb.push_back('{id: 2'd1, x: 1'b0, y: 1'b1});
      #1;
      chk("bp_grant", 32'(req_ready), 32'b0010);
      next_cycle();
      req_valid = 4'hF;
      #1;
      next_cycle();
      for (int c = 0; c < 10; c++) begin
         chk("bp_valid", 32'(rsp_valid), 32'd1);
         chk("bp_rsp", 32'({rsp_id, rsp_x, rsp_y}), 32'b0101);
         chk("bp_dp", 32'({dp_a, dp_b, dp_c, dp_g, dp_p}), 32'b11011);
         chk("bp_ready", 32'(req_ready), 32'd0);
         chk("bp_cnt", 32'(done_cnt), 32'(exp_cnt));
         next_cycle();
      end
      rsp_ready = 1'b1;
      req_valid = '0;
      #1;
      expect_rsp("bp");
      next_cycle();
      exp_cnt++;
      chk("bp_release_cnt", 32'(done_cnt), 32'(exp_cnt));
      chk("bp_release_valid", 32'(rsp_valid), 32'd0);
      next_cycle();
      chk("bp_single_cnt", 32'(done_cnt), 32'(exp_cnt));
      chk("bp_single_busy", 32'(busy), 32'd0);

      // Counter wrap via backdoor preset.
      force dut.done_cnt_q = 16'hFFFF;
      next_cycle();
      release dut.done_cnt_q;
      next_cycle();
      exp_cnt = 16'hFFFF;
      chk("wrap_preset", 32'(done_cnt), 32'hFFFF);
      load(3, tbl[5]);
      run_txn(4'b1000, 3, "wrap", 1'b0);
      chk("wrap_zero", 32'(done_cnt), 32'd0);
      chk("sb_empty", 32'(sb.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
